// File: rtl/ldm_stm_pkg.sv
// Shared types, widths and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_WIDTH  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_WAIT_RSP,
        ST_WB,
        ST_DONE
    } ldm_state_t;

    // Encoded as {pre, up} so the P/U bits cast straight onto the mode
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_t;

    function automatic logic [CNT_WIDTH-1:0] popcount16(input logic [15:0] v);
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + CNT_WIDTH'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_list_pri_enc.sv
// Lowest-set-bit priority encoder over the pending register list.
module reg_list_pri_enc
    import ldm_stm_pkg::*;
(
    input  logic [NUM_REGS-1:0]   list,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  none
);

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        idx  = '0;
        none = (list == '0);
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (list[i]) begin
                idx = ADDR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first, issuing one memory
// request per register and optionally writing the updated base back.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [NUM_REGS-1:0]   reg_list,
    input  logic [WORD_SIZE-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0] base_reg,
    input  logic                  is_load,
    input  logic                  up,
    input  logic                  pre,
    input  logic                  writeback,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] rf_read_reg,
    input  logic [WORD_SIZE-1:0]  rf_read_data,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_reg,
    output logic [WORD_SIZE-1:0]  rf_write_data
);

    ldm_state_t            state_q, state_d;
    logic [NUM_REGS-1:0]   list_q, list_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wb_val_q, wb_val_d;
    logic [ADDR_WIDTH-1:0] base_reg_q, base_reg_d;
    logic                  is_load_q, is_load_d;
    logic                  wb_en_q, wb_en_d;

    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  list_none;
    logic [NUM_REGS-1:0]   list_clr;
    logic [WORD_SIZE-1:0]  span;
    logic [WORD_SIZE-1:0]  addr_step;
    addr_mode_t            mode;
    ldm_state_t            after_xfer;

    reg_list_pri_enc u_pri_enc (
        .list (list_q),
        .idx  (cur_idx),
        .none (list_none)
    );

    // State and latched command
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            base_reg_q <= '0;
            is_load_q  <= 1'b0;
            wb_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            wb_val_q   <= wb_val_d;
            base_reg_q <= base_reg_d;
            is_load_q  <= is_load_d;
            wb_en_q    <= wb_en_d;
        end
    end

    // Next-state, datapath updates and output decode
    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        addr_d     = addr_q;
        wb_val_d   = wb_val_q;
        base_reg_d = base_reg_q;
        is_load_d  = is_load_q;
        wb_en_d    = wb_en_q;

        busy          = 1'b0;
        done          = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        rf_read_reg   = '0;
        rf_write_en   = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;

        mode      = addr_mode_t'({pre, up});
        span      = WORD_SIZE'(popcount16(reg_list)) * WORD_SIZE'(WORD_BYTES);
        addr_step = addr_q + WORD_SIZE'(WORD_BYTES);
        list_clr  = list_q & ~(NUM_REGS'(1) << cur_idx);

        if (list_clr != '0) begin
            after_xfer = ST_XFER;
        end else if (wb_en_q) begin
            after_xfer = ST_WB;
        end else begin
            after_xfer = ST_DONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    list_d     = reg_list;
                    is_load_d  = is_load;
                    base_reg_d = base_reg;
                    wb_val_d   = up ? (base_addr + span) : (base_addr - span);
                    // A loaded base register takes precedence over writeback
                    wb_en_d    = writeback && (reg_list != '0) &&
                                 !(is_load && reg_list[base_reg]);
                    case (mode)
                        MODE_IA: addr_d = base_addr;
                        MODE_IB: addr_d = base_addr + WORD_SIZE'(WORD_BYTES);
                        MODE_DA: addr_d = base_addr - span + WORD_SIZE'(WORD_BYTES);
                        MODE_DB: addr_d = base_addr - span;
                        default: addr_d = base_addr;
                    endcase
                    state_d = (reg_list == '0) ? ST_DONE : ST_XFER;
                end
            end

            ST_XFER: begin
                busy          = 1'b1;
                mem_req_valid = 1'b1;
                mem_addr      = {addr_q[WORD_SIZE-1:2], 2'b00};
                mem_we        = !is_load_q;
                if (!is_load_q) begin
                    rf_read_reg = cur_idx;
                    mem_wdata   = rf_read_data;
                end
                if (list_none) begin
                    state_d = ST_DONE;
                end else if (mem_req_ready) begin
                    if (is_load_q) begin
                        state_d = ST_WAIT_RSP;
                    end else begin
                        list_d  = list_clr;
                        addr_d  = addr_step;
                        state_d = after_xfer;
                    end
                end
            end

            ST_WAIT_RSP: begin
                busy = 1'b1;
                if (mem_rsp_valid) begin
                    rf_write_en   = 1'b1;
                    rf_write_reg  = cur_idx;
                    rf_write_data = mem_rdata;
                    list_d        = list_clr;
                    addr_d        = addr_step;
                    state_d       = after_xfer;
                end
            end

            ST_WB: begin
                busy          = 1'b1;
                rf_write_en   = 1'b1;
                rf_write_reg  = base_reg_q;
                rf_write_data = wb_val_q;
                state_d       = ST_DONE;
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It sits directly upstream of `register_file` and drives its read and write ports. It walks the 16-bit register list from lowest to highest register, issuing one word-aligned memory request per set bit over a valid/ready handshake. It then optionally writes the updated base address back.

## Interface
- `WORD_SIZE`, 32, data/address width
- `NUM_REGS`, 16, register list width
- `ADDR_WIDTH`, 4, register index width
---
- `clk`  in  1  clock; all state updates on posedge
- `rst_b`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `reg_list`  in  NUM_REGS  bit i set = transfer Ri
- `base_addr`  in  WORD_SIZE  value of base register
- `base_reg`  in  ADDR_WIDTH  base register index
- `is_load`  in  1  1 = LDM, 0 = STM
- `up`  in  1  U bit: 1 = increment, 0 = decrement
- `pre`  in  1  P bit: 1 = before, 0 = after
- `writeback`  in  1  W bit
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle completion pulse
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  request accepted when valid & ready
- `mem_addr`  out  WORD_SIZE  word address, bits [1:0] always 0
- `mem_we`  out  1  1 = store
- `mem_wdata`  out  WORD_SIZE  store data
- `mem_rsp_valid`  in  1  load data valid
- `mem_rdata`  in  WORD_SIZE  load data
- `rf_read_reg`  out  ADDR_WIDTH  register file read address (store source)
- `rf_read_data`  in  WORD_SIZE  combinational read data
- `rf_write_en`  out  1  register file write strobe
- `rf_write_reg`  out  ADDR_WIDTH  register file write address
- `rf_write_data`  out  WORD_SIZE  register file write data

## Operation
- States: IDLE, XFER, WAIT_RSP, WB, DONE.
- **Command latch.** On `start` in IDLE, latch the command fields and compute `n = popcount(reg_list)`. Set the start address:
  - IA (`up=1`, `pre=0`): `base`
  - IB (`up=1`, `pre=1`): `base+4`
  - DA (`up=0`, `pre=0`): `base-4n+4`
  - DB (`up=0`, `pre=1`): `base-4n`
- **Ordering.** Registers are always transferred lowest index first, at ascending addresses, +4 per transfer.
- **Writeback value.** `up ? base+4n : base-4n`, computed modulo 2^32. Both wrap-around directions are legal.
- **Empty list.** IDLE -> DONE. No memory request and no writeback.
- **XFER.** `mem_req_valid=1`, and `mem_addr`/`mem_we` are held stable until accepted.
  - Store: `rf_read_reg` = current register; `mem_wdata = rf_read_data`.
  - On accept, a store clears its list bit and goes to the next register, WB, or DONE. A load goes to WAIT_RSP.
- **WAIT_RSP.** Exactly one request is outstanding at a time.
  - On `mem_rsp_valid`, assert `rf_write_en`, `rf_write_reg` = current register, `rf_write_data = mem_rdata` in the same cycle (combinational).
  - Then clear the list bit and go to XFER, WB, or DONE.
- **WB.** Entered only if `writeback=1` and n>0.
  - One cycle: `rf_write_en=1`, `rf_write_reg=base_reg`, `rf_write_data` = writeback value.
  - Skipped if `is_load` and `base_reg` is in the list; the loaded value wins.
- **DONE.** `done=1` for one cycle, then IDLE.
- **Ignored inputs.** `start` is ignored while busy. `mem_rsp_valid` is ignored outside WAIT_RSP.

## Timing
- **Reset.** `rst_b` low forces IDLE immediately. Reset values:
  - All outputs 0: `busy`, `done`, `mem_req_valid`, `mem_we`, `rf_write_en`, addresses, data.
  - Latched list cleared.
  - A response that arrives after reset is dropped.
- **Start latency.** `start` at cycle 0 gives `mem_req_valid` high at cycle 1.
- **Store throughput.** With `mem_req_ready` tied high, one transfer per cycle.
  - Cycles 1..n are XFER.
  - WB at n+1 if taken.
  - `done` at n+2, or at n+1 without writeback.
- **Load throughput.** At least 2 cycles per register: accept, then response. The earliest response is the cycle after accept.
- **Backpressure.** `mem_req_ready` low holds all request outputs unchanged.
- **Reg file writes.** At most one register file write per cycle. Load writes and the base writeback never coincide.

## Structure
- **Package `ldm_stm_pkg`:**
  - state enum `ldm_state_t`
  - `WORD_BYTES = 4`
  - addressing mode typedef {IA, IB, DA, DB}
  - `popcount16` function
- **Sub-module `reg_list_pri_enc`:** lowest-set-bit priority encoder. Inputs: NUM_REGS list. Outputs: ADDR_WIDTH index plus a `none` flag.

## Test plan
- **STM IA.** list=0x000F, base=0x1000, W=1, ready=1, base_reg=R13. Expect:
  - addresses 0x1000/04/08/0C, carrying R0..R3 data
  - R13 written with 0x1010
  - `done` at cycle 6
- **LDM DB.** list=0x8002, base=0x2000, response 1 cycle after accept. Expect:
  - R1 <- mem[0x1FF8], R15 <- mem[0x1FFC]
  - no writeback when W=0
- **LDM IA with base in list.** base_reg=R2, list=0x0004, W=1. Expect R2 = loaded value and no WB write.
- **Empty list.** Expect `done` at cycle 1, zero `mem_req_valid` cycles, and no `rf_write_en`.
- **Wrap-around.** STM IB with base=0xFFFFFFF8 and list=0x0003. Expect addresses 0xFFFFFFFC then 0x00000000, writeback 0x00000000.
- **Backpressure and reset.**
  - Ready low for 3 cycles: `mem_addr` stays stable.
  - `rst_b` low in WAIT_RSP: outputs go 0 immediately, a late `mem_rsp_valid` causes no write, and a new `start` then runs normally.
